// File: rtl/tcp_rx_new_flow_setup.sv
// Slow-path new-flow installer: allocates a flow ID from an internal free list, writes the
// flow-CAM entry, then initialises RX/TX state and buffer indices before signalling done.
module tcp_rx_new_flow_setup #(
    parameter int          FLOWID_W = 3,
    parameter int          TUPLE_W  = 96,
    parameter logic [31:0] ISN_BASE = 32'h1000_0000,
    parameter logic [31:0] ISN_STEP = 32'h0001_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slow_path_val,
    output logic                slow_path_rdy,
    input  logic [TUPLE_W-1:0]  slow_path_tuple,
    input  logic [31:0]         slow_path_seq,
    output logic                slow_path_done_val,
    input  logic                slow_path_done_rdy,
    output logic                slow_path_done_ok,
    output logic                cam_wr_val,
    input  logic                cam_wr_rdy,
    output logic [TUPLE_W-1:0]  cam_wr_tuple,
    output logic [FLOWID_W-1:0] init_flowid,
    output logic                rx_state_init_val,
    input  logic                rx_state_init_rdy,
    output logic [31:0]         rx_state_init_rcv_nxt,
    output logic                tx_state_init_val,
    input  logic                tx_state_init_rdy,
    output logic [31:0]         tx_state_init_isn,
    output logic                idx_init_val,
    input  logic                idx_init_rdy,
    input  logic                flow_free_val,
    output logic                flow_free_rdy,
    input  logic [FLOWID_W-1:0] flow_free_flowid
);

    localparam int                  NUM_FLOWS = 2 ** FLOWID_W;
    localparam int                  CNT_W     = FLOWID_W + 1;
    localparam logic [FLOWID_W-1:0] ONE_ID    = FLOWID_W'(1);
    localparam logic [FLOWID_W-1:0] LAST_ID   = FLOWID_W'(NUM_FLOWS - 1);
    localparam logic [CNT_W-1:0]    ONE_CNT   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ALLOC,
        S_WR_CAM,
        S_WR_STATE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [FLOWID_W-1:0]  init_id_q, init_id_d;
    logic [FLOWID_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FLOWID_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [FLOWID_W-1:0]  mem_q [NUM_FLOWS];

    logic [TUPLE_W-1:0]   tuple_q, tuple_d;
    logic [31:0]          rcv_nxt_q, rcv_nxt_d;
    logic [FLOWID_W-1:0]  flowid_q, flowid_d;
    logic [31:0]          isn_q, isn_d;
    logic [31:0]          tx_isn_q, tx_isn_d;
    logic                 ok_q, ok_d;
    logic                 acc_rx_q, acc_rx_d;
    logic                 acc_tx_q, acc_tx_d;
    logic                 acc_idx_q, acc_idx_d;

    logic                 slow_path_rdy_q, slow_path_rdy_d;
    logic                 flow_free_rdy_q, flow_free_rdy_d;
    logic                 cam_val_q, cam_val_d;
    logic                 rx_val_q, rx_val_d;
    logic                 tx_val_q, tx_val_d;
    logic                 idx_val_q, idx_val_d;
    logic                 done_val_q, done_val_d;

    logic                 push_en;
    logic [FLOWID_W-1:0]  push_id;
    logic                 pop_en;

    // Free-list bookkeeping: INIT seeds IDs in order, afterwards only teardown pushes.
    always_comb begin
        push_en = 1'b0;
        push_id = flow_free_flowid;
        if (state_q == S_INIT) begin
            push_en = 1'b1;
            push_id = init_id_q;
        end else if (flow_free_val && flow_free_rdy_q) begin
            push_en = 1'b1;
        end
        pop_en   = (state_q == S_ALLOC) && (count_q != '0);
        wr_ptr_d = push_en ? wr_ptr_q + ONE_ID : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + ONE_ID : rd_ptr_q;
        count_d  = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + ONE_CNT;
        end else if (!push_en && pop_en) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    always_comb begin
        state_d   = state_q;
        init_id_d = init_id_q;
        tuple_d   = tuple_q;
        rcv_nxt_d = rcv_nxt_q;
        flowid_d  = flowid_q;
        isn_d     = isn_q;
        tx_isn_d  = tx_isn_q;
        ok_d      = ok_q;
        acc_rx_d  = acc_rx_q;
        acc_tx_d  = acc_tx_q;
        acc_idx_d = acc_idx_q;

        case (state_q)
            S_INIT: begin
                init_id_d = init_id_q + ONE_ID;
                if (init_id_q == LAST_ID) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (slow_path_val && slow_path_rdy_q) begin
                    tuple_d   = slow_path_tuple;
                    rcv_nxt_d = slow_path_seq + 32'd1;
                    state_d   = S_ALLOC;
                end
            end
            S_ALLOC: begin
                if (count_q != '0) begin
                    flowid_d = mem_q[rd_ptr_q];
                    // Snapshot the ISN so the TX payload stays stable after isn_q advances.
                    tx_isn_d = isn_q;
                    state_d  = S_WR_CAM;
                end else begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_WR_CAM: begin
                if (cam_wr_rdy) begin
                    state_d = S_WR_STATE;
                end
            end
            S_WR_STATE: begin
                acc_rx_d  = acc_rx_q  | (rx_val_q  & rx_state_init_rdy);
                acc_tx_d  = acc_tx_q  | (tx_val_q  & tx_state_init_rdy);
                acc_idx_d = acc_idx_q | (idx_val_q & idx_init_rdy);
                if (acc_rx_d && acc_tx_d && acc_idx_d) begin
                    ok_d    = 1'b1;
                    isn_d   = isn_q + ISN_STEP;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (slow_path_done_rdy) begin
                    acc_rx_d  = 1'b0;
                    acc_tx_d  = 1'b0;
                    acc_idx_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Handshake outputs are registered copies of the next state.
        slow_path_rdy_d = (state_d == S_IDLE);
        flow_free_rdy_d = (state_d != S_INIT);
        cam_val_d       = (state_d == S_WR_CAM);
        rx_val_d        = (state_d == S_WR_STATE) && !acc_rx_d;
        tx_val_d        = (state_d == S_WR_STATE) && !acc_tx_d;
        idx_val_d       = (state_d == S_WR_STATE) && !acc_idx_d;
        done_val_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_INIT;
            init_id_q       <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tuple_q         <= '0;
            rcv_nxt_q       <= '0;
            flowid_q        <= '0;
            isn_q           <= ISN_BASE;
            tx_isn_q        <= '0;
            ok_q            <= 1'b0;
            acc_rx_q        <= 1'b0;
            acc_tx_q        <= 1'b0;
            acc_idx_q       <= 1'b0;
            slow_path_rdy_q <= 1'b0;
            flow_free_rdy_q <= 1'b0;
            cam_val_q       <= 1'b0;
            rx_val_q        <= 1'b0;
            tx_val_q        <= 1'b0;
            idx_val_q       <= 1'b0;
            done_val_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_id_q       <= init_id_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            tuple_q         <= tuple_d;
            rcv_nxt_q       <= rcv_nxt_d;
            flowid_q        <= flowid_d;
            isn_q           <= isn_d;
            tx_isn_q        <= tx_isn_d;
            ok_q            <= ok_d;
            acc_rx_q        <= acc_rx_d;
            acc_tx_q        <= acc_tx_d;
            acc_idx_q       <= acc_idx_d;
            slow_path_rdy_q <= slow_path_rdy_d;
            flow_free_rdy_q <= flow_free_rdy_d;
            cam_val_q       <= cam_val_d;
            rx_val_q        <= rx_val_d;
            tx_val_q        <= tx_val_d;
            idx_val_q       <= idx_val_d;
            done_val_q      <= done_val_d;
        end
    end

    assign slow_path_rdy         = slow_path_rdy_q;
    assign flow_free_rdy         = flow_free_rdy_q;
    assign cam_wr_val            = cam_val_q;
    assign rx_state_init_val     = rx_val_q;
    assign tx_state_init_val     = tx_val_q;
    assign idx_init_val          = idx_val_q;
    assign slow_path_done_val    = done_val_q;
    assign slow_path_done_ok     = ok_q;
    assign cam_wr_tuple          = tuple_q;
    assign init_flowid           = flowid_q;
    assign rx_state_init_rcv_nxt = rcv_nxt_q;
    assign tx_state_init_isn     = tx_isn_q;

endmodule

// File: tb/tb_tcp_rx_new_flow_setup.sv
// Bench for tcp_rx_new_flow_setup: randomized requests, frees and ready latencies checked
// against a queue-based model of the free list and ISN sequence.
`timescale 1ns/1ps
module tb_tcp_rx_new_flow_setup;

    localparam int          NF       = 8;
    localparam logic [31:0] ISN_BASE = 32'h1000_0000;
    localparam logic [31:0] ISN_STEP = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slow_path_val = 1'b0;
    logic        slow_path_rdy;
    logic [95:0] slow_path_tuple = '0;
    logic [31:0] slow_path_seq = '0;
    logic        slow_path_done_val;
    logic        slow_path_done_rdy = 1'b0;
    logic        slow_path_done_ok;
    logic        cam_wr_val;
    logic        cam_wr_rdy = 1'b0;
    logic [95:0] cam_wr_tuple;
    logic [2:0]  init_flowid;
    logic        rx_state_init_val;
    logic        rx_state_init_rdy = 1'b0;
    logic [31:0] rx_state_init_rcv_nxt;
    logic        tx_state_init_val;
    logic        tx_state_init_rdy = 1'b0;
    logic [31:0] tx_state_init_isn;
    logic        idx_init_val;
    logic        idx_init_rdy = 1'b0;
    logic        flow_free_val = 1'b0;
    logic        flow_free_rdy;
    logic [2:0]  flow_free_flowid = '0;

    tcp_rx_new_flow_setup #(
        .FLOWID_W(3), .TUPLE_W(96), .ISN_BASE(ISN_BASE), .ISN_STEP(ISN_STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .slow_path_val(slow_path_val), .slow_path_rdy(slow_path_rdy),
        .slow_path_tuple(slow_path_tuple), .slow_path_seq(slow_path_seq),
        .slow_path_done_val(slow_path_done_val), .slow_path_done_rdy(slow_path_done_rdy),
        .slow_path_done_ok(slow_path_done_ok),
        .cam_wr_val(cam_wr_val), .cam_wr_rdy(cam_wr_rdy), .cam_wr_tuple(cam_wr_tuple),
        .init_flowid(init_flowid),
        .rx_state_init_val(rx_state_init_val), .rx_state_init_rdy(rx_state_init_rdy),
        .rx_state_init_rcv_nxt(rx_state_init_rcv_nxt),
        .tx_state_init_val(tx_state_init_val), .tx_state_init_rdy(tx_state_init_rdy),
        .tx_state_init_isn(tx_state_init_isn),
        .idx_init_val(idx_init_val), .idx_init_rdy(idx_init_rdy),
        .flow_free_val(flow_free_val), .flow_free_rdy(flow_free_rdy),
        .flow_free_flowid(flow_free_flowid)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: free IDs in FIFO order, IDs currently installed, next ISN.
    int          free_q[$];
    int          busy_q[$];
    logic [31:0] isn_m;

    typedef struct {
        logic        ok;
        logic [2:0]  id;
        logic [95:0] tup;
        logic [31:0] rcv;
        logic [31:0] isn;
        int hs_cam, hs_rx, hs_tx, hs_idx;
        int vc_cam, vc_rx, vc_tx, vc_idx;
        int cam_acc, first_st, last_acc, done_cyc;
        bit unstable, timeout;
    } obs_t;

    function automatic void model_reset();
        free_q.delete();
        busy_q.delete();
        for (int i = 0; i < NF; i++) free_q.push_back(i);
        isn_m = ISN_BASE;
    endfunction

    function automatic void model_free(input int id);
        int keep[$];
        free_q.push_back(id);
        foreach (busy_q[i]) if (busy_q[i] != id) keep.push_back(busy_q[i]);
        busy_q = keep;
    endfunction

    function automatic void model_alloc(input bit fe, input int fid,
                                        output bit ok, output int id, output logic [31:0] isn);
        ok = 1'b0; id = 0; isn = '0;
        if (free_q.size() > 0) begin
            ok  = 1'b1;
            id  = free_q.pop_front();
            isn = isn_m;
            isn_m = isn_m + ISN_STEP;
            busy_q.push_back(id);
        end
        if (fe) model_free(fid);
    endfunction

    task automatic reset_and_count(output int n, output bit bad_free);
        bit up;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0; bad_free = 1'b0; up = 1'b0;
        while (n < 40 && !up) begin
            @(posedge clk); #1;
            n++;
            if (slow_path_rdy === 1'b1) up = 1'b1;
            else if (flow_free_rdy !== 1'b0) bad_free = 1'b1;
        end
    endtask

    task automatic drive_free(input logic [2:0] id);
        @(negedge clk);
        flow_free_val = 1'b1; flow_free_flowid = id;
        @(negedge clk);
        flow_free_val = 1'b0;
    endtask

    // Issues one request and records what the DUT did; cycle numbers count from the ALLOC cycle.
    task automatic run_request(input logic [95:0] tup, input logic [31:0] seq,
                               input int cl, input int rl, input int tl, input int il, input int dl,
                               input bit fe, input logic [2:0] fid, output obs_t o);
        int cyc, cc, rc, tc, ic, dc;
        bit cap, fin;
        o = '{default: 0};
        o.cam_acc = -1; o.first_st = -1; o.last_acc = -1; o.done_cyc = -1;
        cc = 0; rc = 0; tc = 0; ic = 0; dc = 0; cap = 1'b0; fin = 1'b0;
        @(negedge clk);
        slow_path_val = 1'b1; slow_path_tuple = tup; slow_path_seq = seq;
        cyc = 0;
        while (slow_path_rdy !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        if (slow_path_rdy !== 1'b1) begin
            o.timeout = 1'b1; slow_path_val = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        slow_path_val = 1'b0; slow_path_tuple = ~tup; slow_path_seq = $urandom;
        flow_free_val = fe; flow_free_flowid = fid;
        cyc = 0;
        while (!fin && cyc < 200) begin
            if (cyc == 1) flow_free_val = 1'b0;
            cam_wr_rdy         = cam_wr_val         ? (cc >= cl) : 1'($urandom_range(1));
            rx_state_init_rdy  = rx_state_init_val  ? (rc >= rl) : 1'($urandom_range(1));
            tx_state_init_rdy  = tx_state_init_val  ? (tc >= tl) : 1'($urandom_range(1));
            idx_init_rdy       = idx_init_val       ? (ic >= il) : 1'($urandom_range(1));
            slow_path_done_rdy = slow_path_done_val ? (dc >= dl) : 1'b0;
            if (cam_wr_val) begin
                if (!cap) begin
                    o.id = init_flowid; o.tup = cam_wr_tuple;
                    o.rcv = rx_state_init_rcv_nxt; o.isn = tx_state_init_isn;
                    cap = 1'b1;
                end
                o.vc_cam++; cc++;
                if (cam_wr_rdy) begin o.hs_cam++; o.cam_acc = cyc; end
            end
            if (cap && (init_flowid !== o.id || cam_wr_tuple !== o.tup ||
                        rx_state_init_rcv_nxt !== o.rcv || tx_state_init_isn !== o.isn))
                o.unstable = 1'b1;
            if ((rx_state_init_val || tx_state_init_val || idx_init_val) && o.first_st < 0)
                o.first_st = cyc;
            if (rx_state_init_val) begin
                o.vc_rx++; rc++;
                if (rx_state_init_rdy) begin o.hs_rx++; o.last_acc = cyc; end
            end
            if (tx_state_init_val) begin
                o.vc_tx++; tc++;
                if (tx_state_init_rdy) begin o.hs_tx++; o.last_acc = cyc; end
            end
            if (idx_init_val) begin
                o.vc_idx++; ic++;
                if (idx_init_rdy) begin o.hs_idx++; o.last_acc = cyc; end
            end
            if (slow_path_done_val) begin
                if (o.done_cyc < 0) begin o.done_cyc = cyc; o.ok = slow_path_done_ok; end
                dc++;
                if (slow_path_done_rdy) fin = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) o.timeout = 1'b1;
        flow_free_val = 1'b0; slow_path_done_rdy = 1'b0; cam_wr_rdy = 1'b0;
        rx_state_init_rdy = 1'b0; tx_state_init_rdy = 1'b0; idx_init_rdy = 1'b0;
    endtask

    task automatic test_reset();
        int n; bit bad;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        vecs++;
        if ({slow_path_rdy, slow_path_done_val, slow_path_done_ok, cam_wr_val, rx_state_init_val,
             tx_state_init_val, idx_init_val, flow_free_rdy} !== 8'h00) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 00000000", {slow_path_rdy, slow_path_done_val,
                     slow_path_done_ok, cam_wr_val, rx_state_init_val, tx_state_init_val,
                     idx_init_val, flow_free_rdy});
        end
        vecs++;
        if ({init_flowid, cam_wr_tuple, rx_state_init_rcv_nxt, tx_state_init_isn} !== '0) begin
            errs++;
            $display("FAIL reset_data: got id=%0d rcv=%h isn=%h want zeros", init_flowid,
                     rx_state_init_rcv_nxt, tx_state_init_isn);
        end
        reset_and_count(n, bad);
        vecs++;
        if (n != NF) begin errs++; $display("FAIL init_cycles: got %0d want %0d", n, NF); end
        vecs++;
        if (bad) begin errs++; $display("FAIL init_free_rdy: got 1 during INIT want 0"); end
        model_reset();
    endtask

    task automatic test_basic();
        logic [95:0] tups [2];
        logic [31:0] seqs [2];
        obs_t o; bit eok; int eid; logic [31:0] eisn, erc;
        tups[0] = 96'hC0A8_0001_0A00_0002_1F90_0050;
        seqs[0] = 32'hFFFF_FFFF;
        tups[1] = {$urandom, $urandom, $urandom};
        seqs[1] = $urandom;
        for (int i = 0; i < 2; i++) begin
            model_alloc(1'b0, 0, eok, eid, eisn);
            erc = seqs[i] + 32'd1;
            run_request(tups[i], seqs[i], 0, 0, 0, 0, 0, 1'b0, 3'd0, o);
            vecs++;
            if (o.timeout || o.ok !== eok) begin
                errs++; $display("FAIL basic%0d_ok: got ok=%b to=%0d want ok=%b", i, o.ok, o.timeout, eok);
            end
            vecs++;
            if (o.id !== eid[2:0]) begin errs++; $display("FAIL basic%0d_id: got %0d want %0d", i, o.id, eid); end
            vecs++;
            if (o.rcv !== erc) begin errs++; $display("FAIL basic%0d_rcv: got %h want %h", i, o.rcv, erc); end
            vecs++;
            if (o.isn !== eisn) begin errs++; $display("FAIL basic%0d_isn: got %h want %h", i, o.isn, eisn); end
            vecs++;
            if (o.tup !== tups[i]) begin errs++; $display("FAIL basic%0d_tuple: got %h want %h", i, o.tup, tups[i]); end
            vecs++;
            if (o.done_cyc != 3 || o.unstable) begin
                errs++; $display("FAIL basic%0d_timing: got done_cyc=%0d unstable=%0d want 3/0", i, o.done_cyc, o.unstable);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o; bit eok; int eid; logic [31:0] eisn;
        model_alloc(1'b0, 0, eok, eid, eisn);
        run_request({$urandom, $urandom, $urandom}, $urandom, 2, 5, 0, 0, 1, 1'b0, 3'd0, o);
        vecs++;
        if (o.timeout || o.ok !== eok || o.id !== eid[2:0] || o.isn !== eisn) begin
            errs++; $display("FAIL bp_result: got ok=%b id=%0d isn=%h want ok=%b id=%0d isn=%h",
                             o.ok, o.id, o.isn, eok, eid, eisn);
        end
        vecs++;
        if (o.hs_cam != 1 || o.hs_rx != 1 || o.hs_tx != 1 || o.hs_idx != 1) begin
            errs++; $display("FAIL bp_handshakes: got cam=%0d rx=%0d tx=%0d idx=%0d want 1 each",
                             o.hs_cam, o.hs_rx, o.hs_tx, o.hs_idx);
        end
        vecs++;
        if (o.vc_cam != 3 || o.vc_rx != 6 || o.vc_tx != 1 || o.vc_idx != 1) begin
            errs++; $display("FAIL bp_val_cycles: got cam=%0d rx=%0d tx=%0d idx=%0d want 3/6/1/1",
                             o.vc_cam, o.vc_rx, o.vc_tx, o.vc_idx);
        end
        vecs++;
        if (o.done_cyc != o.last_acc + 1) begin
            errs++; $display("FAIL bp_done_lat: got done at %0d want %0d", o.done_cyc, o.last_acc + 1);
        end
        vecs++;
        if (o.first_st != o.cam_acc + 1 || o.cam_acc < 0) begin
            errs++; $display("FAIL bp_cam_first: got state at %0d want %0d", o.first_st, o.cam_acc + 1);
        end
    endtask

    task automatic test_exhaust();
        obs_t o; bit eok; int eid; logic [31:0] eisn;
        for (int i = 0; i < 6; i++) begin
            model_alloc(1'b0, 0, eok, eid, eisn);
            run_request({$urandom, $urandom, $urandom}, $urandom, $urandom_range(3), $urandom_range(3),
                        $urandom_range(3), $urandom_range(3), 0, 1'b0, 3'd0, o);
            vecs++;
            if (o.timeout || o.ok !== eok) begin
                errs++; $display("FAIL exhaust%0d_ok: got ok=%b to=%0d want ok=%b", i, o.ok, o.timeout, eok);
            end
            vecs++;
            if (eok) begin
                if (o.id !== eid[2:0] || o.isn !== eisn) begin
                    errs++; $display("FAIL exhaust%0d_id: got id=%0d isn=%h want id=%0d isn=%h", i, o.id, o.isn, eid, eisn);
                end
            end else if (o.vc_cam + o.vc_rx + o.vc_tx + o.vc_idx != 0 || o.done_cyc != 1) begin
                errs++; $display("FAIL exhaust%0d_noinstall: got val_cycles=%0d done_cyc=%0d want 0/1", i,
                                 o.vc_cam + o.vc_rx + o.vc_tx + o.vc_idx, o.done_cyc);
            end
        end
        drive_free(3'd5);
        model_free(5);
        model_alloc(1'b0, 0, eok, eid, eisn);
        run_request({$urandom, $urandom, $urandom}, $urandom, 0, 0, 0, 0, 0, 1'b0, 3'd0, o);
        vecs++;
        if (o.timeout || o.ok !== 1'b1 || o.id !== 3'd5 || o.isn !== eisn) begin
            errs++; $display("FAIL exhaust_refree: got ok=%b id=%0d isn=%h want ok=1 id=5 isn=%h", o.ok, o.id, o.isn, eisn);
        end
    endtask

    task automatic test_free_during_alloc();
        bit fe [5];
        logic [2:0] fid [5];
        obs_t o; bit eok; int eid; logic [31:0] eisn;
        fe  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        fid = '{3'd3, 3'd0, 3'd0, 3'd1, 3'd0};
        drive_free(3'd2); model_free(2);
        drive_free(3'd6); model_free(6);
        for (int i = 0; i < 5; i++) begin
            model_alloc(fe[i], int'(fid[i]), eok, eid, eisn);
            run_request({$urandom, $urandom, $urandom}, $urandom, 0, $urandom_range(2), 0, 0, 0, fe[i], fid[i], o);
            vecs++;
            if (o.timeout || o.ok !== eok || (eok && (o.id !== eid[2:0] || o.isn !== eisn))) begin
                errs++; $display("FAIL fda%0d: got ok=%b id=%0d isn=%h want ok=%b id=%0d isn=%h",
                                 i, o.ok, o.id, o.isn, eok, eid, eisn);
            end
        end
    endtask

    task automatic test_random_mix();
        obs_t o; bit eok, fe; int eid, fid; logic [31:0] eisn, seq, erc;
        logic [95:0] tup;
        for (int i = 0; i < 30; i++) begin
            if (busy_q.size() > 0 && $urandom_range(9) < 4) begin
                fid = busy_q[$urandom_range(busy_q.size() - 1)];
                drive_free(fid[2:0]);
                model_free(fid);
            end else begin
                fe  = (busy_q.size() > 0) && ($urandom_range(3) == 0);
                fid = fe ? busy_q[$urandom_range(busy_q.size() - 1)] : 0;
                tup = {$urandom, $urandom, $urandom};
                seq = $urandom;
                erc = seq + 32'd1;
                model_alloc(fe, fid, eok, eid, eisn);
                run_request(tup, seq, $urandom_range(3), $urandom_range(4), $urandom_range(4),
                            $urandom_range(4), $urandom_range(2), fe, fid[2:0], o);
                vecs++;
                if (o.timeout || o.ok !== eok) begin
                    errs++; $display("FAIL mix%0d_ok: got ok=%b to=%0d want ok=%b", i, o.ok, o.timeout, eok);
                end
                vecs++;
                if (eok) begin
                    if (o.id !== eid[2:0] || o.isn !== eisn || o.rcv !== erc || o.tup !== tup ||
                        o.unstable || o.hs_rx != 1 || o.hs_tx != 1 || o.hs_idx != 1 ||
                        o.done_cyc != o.last_acc + 1 || o.first_st != o.cam_acc + 1) begin
                        errs++; $display("FAIL mix%0d_install: got id=%0d isn=%h rcv=%h uns=%0d hs=%0d%0d%0d done=%0d want id=%0d isn=%h rcv=%h uns=0 hs=111 done=%0d",
                                         i, o.id, o.isn, o.rcv, o.unstable, o.hs_rx, o.hs_tx, o.hs_idx,
                                         o.done_cyc, eid, eisn, erc, o.last_acc + 1);
                    end
                end else if (o.vc_cam + o.vc_rx + o.vc_tx + o.vc_idx != 0) begin
                    errs++; $display("FAIL mix%0d_noinstall: got val_cycles=%0d want 0", i,
                                     o.vc_cam + o.vc_rx + o.vc_tx + o.vc_idx);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; bit eok, bad; int eid, n, cyc; logic [31:0] eisn;
        @(negedge clk);
        slow_path_val = 1'b1; slow_path_tuple = {$urandom, $urandom, $urandom}; slow_path_seq = $urandom;
        cyc = 0;
        while (slow_path_rdy !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(negedge clk);
        slow_path_val = 1'b0;
        cam_wr_rdy = 1'b1; rx_state_init_rdy = 1'b0; tx_state_init_rdy = 1'b1; idx_init_rdy = 1'b1;
        cyc = 0;
        while (rx_state_init_val !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        vecs++;
        if (rx_state_init_val !== 1'b1) begin errs++; $display("FAIL rstmid_reach: got no WR_STATE want rx val"); end
        rst = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if ({slow_path_rdy, slow_path_done_val, cam_wr_val, rx_state_init_val, tx_state_init_val,
             idx_init_val, flow_free_rdy} !== 7'h00) begin
            errs++; $display("FAIL rstmid_vals: got %b want 0000000", {slow_path_rdy, slow_path_done_val,
                             cam_wr_val, rx_state_init_val, tx_state_init_val, idx_init_val, flow_free_rdy});
        end
        cam_wr_rdy = 1'b0; tx_state_init_rdy = 1'b0; idx_init_rdy = 1'b0;
        reset_and_count(n, bad);
        vecs++;
        if (n != NF || bad) begin errs++; $display("FAIL rstmid_init: got %0d cycles bad=%0d want %0d/0", n, bad, NF); end
        model_reset();
        model_alloc(1'b0, 0, eok, eid, eisn);
        run_request({$urandom, $urandom, $urandom}, $urandom, 0, 0, 0, 0, 0, 1'b0, 3'd0, o);
        vecs++;
        if (o.timeout || o.ok !== eok || o.id !== eid[2:0] || o.isn !== eisn) begin
            errs++; $display("FAIL rstmid_req: got ok=%b id=%0d isn=%h want ok=%b id=%0d isn=%h",
                             o.ok, o.id, o.isn, eok, eid, eisn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_exhaust();
        test_free_during_alloc();
        test_random_mix();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
